apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- Synthesizable APB initiator that turns a simple valid/ready command stream into APB3 read/write transfers toward peripherals such as grgpio.
- Returns read data, slave error and a timeout flag on a valid/ready response channel.
- Sits between an on-chip command source (debug bridge or sequencer) and the APB slave bus. It replaces the behavioural bus-driver tasks with RTL.

Parameters:
ADDR_W, 32, width of paddr and cmd_addr
DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Reset: rstn low at a rising edge forces the following state:
  - state=IDLE.
  - psel, penable, rsp_valid, rsp_err, rsp_timeout = 0.
  - paddr, pwdata, rsp_rdata = 0; pwrite = 0.
  - cmd_ready is 1 from the first cycle after reset.
  - A reset mid-transfer abandons the transfer with no response. psel and penable drop at that edge.
- FSM states:
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid: latch cmd_write/addr/wdata onto pwrite/paddr/pwdata, go to SETUP.
    - Reads drive pwdata=0.
  - SETUP:
    - Exactly 1 cycle; psel=1, penable=0, cmd_ready=0.
    - Clear the wait counter. Go to ACCESS.
  - ACCESS:
    - psel=1, penable=1.
    - Each cycle with pready=0, increment the wait counter.
    - pready=1:
      - Sample pslverr into rsp_err.
      - Sample prdata into rsp_rdata on reads; rsp_rdata=0 on writes.
      - Drop psel/penable at the same edge and go to RESP.
    - TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0:
      - Drop psel/penable.
      - rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
    - pready=1 takes priority over the timeout in the same cycle.
  - RESP:
    - rsp_valid=1; response outputs held stable.
    - On rsp_ready: rsp_valid=0, clear rsp_err/rsp_timeout, go to IDLE.
- paddr, pwrite and pwdata are stable from SETUP through the final ACCESS cycle. They hold their last value in IDLE/RESP and do not toggle.
- Latency:
  - Command accepted at edge N: SETUP in cycle N+1, first ACCESS in cycle N+2.
  - With zero-wait pready, rsp_valid is high in cycle N+3.
  - Minimum spacing between accepted commands is 4 cycles when rsp_ready is tied high.
- Only one outstanding transfer. cmd_ready=0 outside IDLE; cmd_valid is ignored there.
- The wait counter is sized $clog2(TIMEOUT+1) bits and saturates. It never wraps.
- pslverr and prdata are ignored except in the ACCESS cycle where pready=1.

Test Plan:
- Write 0x55 to addr 0x0C, pready tied 1:
  - psel high 2 cycles; penable high only in the 2nd.
  - pwrite=1, pwdata=0x55 stable throughout.
  - rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x00, slave drives prdata=0xA5 with 3 pready-low cycles -> penable high 4 cycles; rsp_rdata=0xA5, rsp_err=0.
- Read with pslverr=1 on the ready cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- TIMEOUT=16, pready held 0:
  - Abort after 16 ACCESS cycles; psel/penable drop.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A following write to 0x04 completes normally.
- Back-to-back 256 writes (data i to 0x04) with rsp_ready random:
  - cmd_ready low whenever rsp_valid is pending.
  - Each transfer is exactly one SETUP and one or more ACCESS cycles.
  - Response order matches command order.
- rstn driven low during the ACCESS of a read -> next edge: psel=0, penable=0, rsp_valid=0, cmd_ready=1. No stale response afterwards.

Source files
------------

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: groups the command, response and APB bus signals of
// apb_master_ctrl into one bundle.
//   master modport: the controller's view (drives cmd_ready, rsp_*, APB request)
//   slave  modport: the environment's view (command source, response sink, APB slave)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout response channel
//   psel/penable/paddr/pwrite/pwdata/prdata/pready/pslverr APB3 bus
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, paddr, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 initiator converting a valid/ready command stream into
// single APB read/write transfers and returning read data, slave error and a
// timeout flag on a valid/ready response channel. One transfer outstanding.
// Ports:
//   clk   - clock, rising edge
//   rstn  - synchronous active-low reset
//   bus   - apb_master_ctrl_if.master (command, response and APB signals)
// Parameters:
//   ADDR_W, DATA_W - address / data widths (must match the interface)
//   TIMEOUT        - ACCESS cycles with pready low before abort; 0 disables
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rstn,
    apb_master_ctrl_if.master   bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires in the ACCESS cycle that would be the TIMEOUT-th low-pready cycle.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e             state_q,       state_d;
    logic [ADDR_W-1:0]  paddr_q,       paddr_d;
    logic               pwrite_q,      pwrite_d;
    logic [DATA_W-1:0]  pwdata_q,      pwdata_d;
    logic [DATA_W-1:0]  rsp_rdata_q,   rsp_rdata_d;
    logic               rsp_err_q,     rsp_err_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]   wait_cnt_q,    wait_cnt_d;
    logic               timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // pready wins over a coincident timeout.
                if (bus.pready) begin
                    rsp_err_d     = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    state_d       = RESP;
                end else if (timeout_hit) begin
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Bus strobes decode straight from the state register so they drop on the
    // same edge that leaves ACCESS (or that applies reset).
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable     = (state_q == ACCESS);
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed scoreboard bench for apb_master_ctrl.
// The stimulus task pushes the expected response on command acceptance; a
// separate monitor pops and compares on every response handshake and also
// checks APB framing (one SETUP, stable address/data, penable count, latency).
module tb_apb_master_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    int vectors     = 0;
    int miscompares = 0;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- APB slave model ----------------
    int          wait_cycles = 0;
    bit          hang        = 1'b0;
    logic [31:0] rd_data     = '0;
    bit          slv_err     = 1'b0;
    int          acc_cnt     = 0;

    assign bus.pready  = bus.psel && bus.penable && !hang && (acc_cnt == wait_cycles);
    // Garbage outside the ready cycle: the DUT must ignore it.
    assign bus.prdata  = bus.pready ? rd_data : 32'hDEAD_BEEF;
    assign bus.pslverr = bus.pready ? slv_err : 1'b1;

    always @(posedge clk) begin
        if (!rstn)                                        acc_cnt <= 0;
        else if (bus.psel && bus.penable && !bus.pready)  acc_cnt <= acc_cnt + 1;
        else                                              acc_cnt <= 0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          pen;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: drives rsp_ready and checks everything at the falling edge.
    initial begin
        logic [31:0] s_addr, s_wdata;
        logic        s_wr;
        logic        prev_rv;
        int          pen_cnt, psel_cnt, m_lat, m_pen, m_psel;
        exp_t        e;
        s_addr = '0; s_wdata = '0; s_wr = 1'b0; prev_rv = 1'b0;
        pen_cnt = 0; psel_cnt = 0; m_lat = 0; m_pen = 0; m_psel = 0;
        bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.psel && !bus.penable) begin
                psel_cnt = 1; pen_cnt = 0;
                s_addr = bus.paddr; s_wr = bus.pwrite; s_wdata = bus.pwdata;
            end else if (bus.psel && bus.penable) begin
                psel_cnt++; pen_cnt++;
                chk("paddr_stable",  bus.paddr,  s_addr);
                chk("pwrite_stable", 32'(bus.pwrite), 32'(s_wr));
                chk("pwdata_stable", bus.pwdata, s_wdata);
            end
            if (bus.rsp_valid) begin
                chk("cmd_ready_low_in_resp", 32'(bus.cmd_ready), 32'd0);
                if (!prev_rv) begin
                    m_pen = pen_cnt; m_psel = psel_cnt;
                    m_lat = (exp_q.size() > 0) ? cyc - exp_q[0].acc_cyc : -1;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata",   bus.rsp_rdata, e.rdata);
                    chk("rsp_err",     32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
                    chk("paddr",       s_addr,  e.addr);
                    chk("pwrite",      32'(s_wr), 32'(e.wr));
                    chk("pwdata",      s_wdata, e.wdata);
                    chk("one_setup",   32'(m_psel), 32'(m_pen + 1));
                    if (e.pen >= 0) chk("penable_cycles", 32'(m_pen), 32'(e.pen));
                    if (e.lat >= 0) chk("rsp_latency",    32'(m_lat), 32'(e.lat));
                end
            end
            prev_rv = bus.rsp_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdat, input bit serr, input int waits, input bit hng,
                          input bit push, input logic [31:0] x_rdata, input bit x_err,
                          input bit x_to, input int x_pen, input int x_lat);
        exp_t e;
        int   k;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        k = 0;
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        // Accept happens at the coming rising edge; slave behaviour for this transfer set now.
        wait_cycles = waits; hang = hng; rd_data = rdat; slv_err = serr;
        if (push) begin
            e.addr = addr; e.wr = wr; e.wdata = wr ? wdata : 32'h0;
            e.rdata = x_rdata; e.err = x_err; e.to = x_to;
            e.pen = x_pen; e.lat = x_lat; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        int w;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel",        32'(bus.psel), 32'd0);
        chk("rst_penable",     32'(bus.penable), 32'd0);
        chk("rst_rsp_valid",   32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",     32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_paddr",       bus.paddr, 32'd0);
        chk("rst_pwdata",      bus.pwdata, 32'd0);
        chk("rst_pwrite",      32'(bus.pwrite), 32'd0);
        chk("rst_rsp_rdata",   bus.rsp_rdata, 32'd0);
        chk("rst_cmd_ready",   32'(bus.cmd_ready), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        //     wr   addr       wdata      rdat       serr wt hang push xrdata     xerr xto pen lat
        do_cmd(1, 32'h0C, 32'h55,    32'h0,     0,   0, 0,   1, 32'h0,     0,   0,  1,  3);
        do_cmd(0, 32'h00, 32'h1234,  32'hA5,    0,   3, 0,   1, 32'hA5,    0,   0,  4,  6);
        do_cmd(0, 32'h08, 32'h0,     32'h3C,    1,   1, 0,   1, 32'h3C,    1,   0,  2,  4);
        do_cmd(1, 32'h14, 32'hAA,    32'h0,     1,   0, 0,   1, 32'h0,     1,   0,  1,  3);
        do_cmd(0, 32'h10, 32'h0,     32'h5A,    0,   0, 1,   1, 32'h0,     1,   1, 16, 18);
        do_cmd(1, 32'h04, 32'h77,    32'h0,     0,   0, 0,   1, 32'h0,     0,   0,  1,  3);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = $urandom_range(0, 2);
            do_cmd(1, 32'h04, 32'(i), 32'h0, 0, w, 0, 1, 32'h0, 0, 0, w + 1, w + 3);
        end
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_back_to_back", 32'(exp_q.size()), 32'd0);
        rnd_rdy = 1'b0;

        // Reset in the middle of a read ACCESS: transfer abandoned, no response.
        do_cmd(0, 32'h20, 32'h0, 32'h11, 0, 0, 1, 0, 32'h0, 0, 0, -1, -1);
        repeat (3) @(negedge clk);
        chk("pre_rst_penable", 32'(bus.penable), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_psel",      32'(bus.psel), 32'd0);
        chk("midrst_penable",   32'(bus.penable), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rstn = 1'b1;
        hang = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        do_cmd(1, 32'h08, 32'h99, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 3);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_final", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
